demux_8bit_deser: RTL and testbench
===================================

# demux_8bit_deser

Serial-to-parallel demultiplexer that reassembles 8-bit words from a serial bit stream. The transmit side drives that stream by stepping an 8:1 mux select from 0 to 7. Each accepted bit is steered to output lane 0..7 by an internal 3-bit lane counter. Completed words are held in an output register with a valid/ready handshake. The block sits on the receive side of the bit-serial operand path into the ALU.

## Interface
Parameters: none; word width is fixed at 8 lanes.
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_bit  input  1  serial data bit
- in_valid  input  1  in_bit is valid this cycle
- in_sof  input  1  start-of-frame; qualifies the bit accepted this cycle as lane 0
- in_ready  output  1  block can accept a bit this cycle (combinational)
- out_word  output  8  assembled word; lane k = out_word[k]
- out_valid  output  1  out_word holds an unconsumed word
- out_ready  input  1  downstream consumes out_word when out_valid && out_ready
- lane  output  3  lane the next accepted bit will fill (registered counter)
- parity_err  output  1  present only with DEMUX_PARITY_EN; parity result for the word in out_word

## Operation
- Reset values: lane=0, collect register=0, out_word=8'h00, out_valid=0, parity_err=0.
- Accept condition: a bit is accepted on any edge where in_valid && in_ready.
- Accepted bit goes into collect[lane], and lane increments.
- Accepted bit with in_sof=1:
  - The bit goes to lane 0, and lane becomes 1.
  - Any partial frame is discarded without any output.
- Frame completion: the accept at lane==7 completes a frame.
  - collect with the new bit in [7] is copied to out_word.
  - out_valid is set to 1 and lane wraps to 0.
- in_ready = !(lane==LAST && out_valid && !out_ready).
  - LAST = 7, or 8 with parity enabled.
  - Collection continues while a previous word waits. Only the completing bit stalls.
- Output drain: when out_valid && out_ready and no frame completes on the same edge, out_valid clears. out_word keeps its value.
- Simultaneous drain and completion: out_word is loaded with the new word and out_valid stays 1. No bubble and no word is lost.
- in_valid=0 leaves all collection state unchanged. Gaps between bits are allowed.
- out_word and out_valid ignore in_sof while no frame completes.

## Timing
- Latency: out_valid and out_word update on the same edge that accepts the final bit of the frame. They are visible the cycle after the final bit is presented.
- Throughput: one bit per cycle. That is one word per 8 cycles, or per 9 cycles with parity.
- lane is visible one cycle after each accept.
- in_ready has a combinational path from out_ready.
- reset overrides all other inputs on the same edge. A frame in progress and any pending out_word are dropped.

## Configuration
- DEMUX_PARITY_EN defined:
  - A frame is 9 bits; the 9th bit at lane==8 is an even-parity bit over bits 0..7. lane counts 0..8.
  - On completion, parity_err = ^{data, parity_bit}, registered with out_word. It is cleared by reset only and updated on each completion.
- DEMUX_PARITY_EN undefined:
  - Frames are 8 bits and lane counts 0..7.
  - The parity_err port and its logic are absent.

## Test plan
- Reset and fill: after reset, stream bits 0,1,0,1,1,0,0,1 in lane order with in_valid=1 and out_ready=1. Required: out_word=8'h9A and out_valid=1 for exactly one cycle after the 8th bit; lane returns to 0.
- Backpressure:
  - Hold out_ready=0 after a word of 8'hFF and stream 7 bits of the next word. Required: in_ready=1 through lane 6 and in_ready=0 at lane 7; out_word stays 8'hFF.
  - Then raise out_ready. Required: the 8th bit is accepted, out_word=8'h00, and out_valid stays 1.
- Resync: send 5 bits, then assert in_sof with bit 1 and 7 more bits of 0. Required: out_word=8'h01, and no word was emitted for the partial frame.
- Gaps: 8'hC3 sent with in_valid toggling 1/0 each cycle. Required: out_word=8'hC3 after 15 cycles, and lane holds during gaps.
- Mid-frame reset: reset after 4 bits, then send 8'h5A. Required: out_word=8'h5A with no corruption from the earlier bits.
- Parity (DEMUX_PARITY_EN): data 8'h07 with parity bit 1 gives parity_err=0. Data 8'h07 with parity bit 0 gives parity_err=1.

Source files
------------

// File: rtl/demux_8bit_deser.sv
// demux_8bit_deser: serial-to-parallel receiver that rebuilds 8-bit words from a
// bit stream. Each accepted bit is steered into lane 0..7 by a lane counter, and
// finished words are held in a valid/ready output register.
//
// Optional feature macro: DEMUX_PARITY_EN. When it is defined, a frame carries a
// 9th even-parity bit, the lane counter runs 0..8 (4 bits wide), and parity_err
// is registered with each word.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_bit     serial data bit
//   in_valid   in_bit is valid this cycle
//   in_sof     start of frame: the bit accepted this cycle goes to lane 0
//   in_ready   a bit can be accepted this cycle (combinational from out_ready)
//   out_word   assembled word, lane k = out_word[k]
//   out_valid  out_word holds an unconsumed word
//   out_ready  downstream takes out_word when out_valid && out_ready
//   lane       lane the next accepted bit will fill
//   parity_err parity result for out_word (DEMUX_PARITY_EN only)
module demux_8bit_deser (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] out_word,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef DEMUX_PARITY_EN
  output logic [3:0] lane,
  output logic       parity_err
`else
  output logic [2:0] lane
`endif
);

`ifdef DEMUX_PARITY_EN
  localparam int unsigned LaneW = 4;
  localparam int unsigned CollW = 8;
  localparam logic [LaneW-1:0] Last = 4'd8;
`else
  localparam int unsigned LaneW = 3;
  // Lane 7 is never stored in collect; it goes straight into out_word.
  localparam int unsigned CollW = 7;
  localparam logic [LaneW-1:0] Last = 3'd7;
`endif

  logic [LaneW-1:0] lane_q, lane_d;
  logic [CollW-1:0] collect_q, collect_d;
  logic [7:0]       word_q, word_d;
  logic             valid_q, valid_d;
  logic             accept;

`ifdef DEMUX_PARITY_EN
  logic perr_q, perr_d;
`endif

  // Only the frame-completing bit stalls, and only while the held word is blocked.
  always_comb begin
    in_ready = !((lane_q == Last) && valid_q && !out_ready);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    lane_d    = lane_q;
    collect_d = collect_q;
    word_d    = word_q;
    valid_d   = valid_q;
`ifdef DEMUX_PARITY_EN
    perr_d    = perr_q;
`endif
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (in_sof) begin
        // Resync: drop any partial frame and restart at lane 0.
        collect_d    = '0;
        collect_d[0] = in_bit;
        lane_d       = LaneW'(1);
      end else if (lane_q == Last) begin
        lane_d  = '0;
        valid_d = 1'b1;  // overrides a same-edge drain: no bubble
`ifdef DEMUX_PARITY_EN
        word_d  = collect_q;
        perr_d  = ^{collect_q, in_bit};
`else
        word_d  = {in_bit, collect_q};
`endif
      end else begin
        collect_d[lane_q[2:0]] = in_bit;
        lane_d                 = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q    <= '0;
      collect_q <= '0;
      word_q    <= 8'h00;
      valid_q   <= 1'b0;
`ifdef DEMUX_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      lane_q    <= lane_d;
      collect_q <= collect_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
`ifdef DEMUX_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign lane      = lane_q;
  assign out_word  = word_q;
  assign out_valid = valid_q;
`ifdef DEMUX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_demux_8bit_deser.sv
// Testbench for demux_8bit_deser. Directed scenarios plus a randomized phase. A
// frame-level reference model turns accepted bits into expected words, which go
// into a queue; a monitor pops them and checks each word the DUT hands over.
module tb_demux_8bit_deser;

`ifdef DEMUX_PARITY_EN
  localparam int FrameLen = 9;
  logic [3:0] lane;
  logic       parity_err;
`else
  localparam int FrameLen = 8;
  logic [2:0] lane;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       in_bit, in_valid, in_sof, in_ready;
  logic [7:0] out_word;
  logic       out_valid, out_ready;

  always #5 clock = ~clock;

  demux_8bit_deser dut (
    .clock     (clock),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX_PARITY_EN
    .lane      (lane),
    .parity_err(parity_err)
`else
    .lane      (lane)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: bits of the frame in progress, words owed to the monitor,
  // whether a word is outstanding, and the last completed word/parity result.
  bit         frame[$];
  logic [7:0] exp_word_q[$];
  logic       exp_perr_q[$];
  bit         pend;
  logic [7:0] cur_word;
  logic       cur_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake consumes the oldest expected word.
  always @(negedge clock) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_word_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %0h, expected no word at %0t", out_word, $time);
      end else begin
        logic [7:0] w;
        logic       p;
        w = exp_word_q.pop_front();
        p = exp_perr_q.pop_front();
        chk("out_word", {24'd0, out_word}, {24'd0, w});
`ifdef DEMUX_PARITY_EN
        chk("parity_err", {31'd0, parity_err}, {31'd0, p});
`else
        if (p !== 1'b0) chk("parity_model", 32'd0, 32'd1);
`endif
      end
    end
  end

  // One clock of stimulus. Checks the DUT's visible state before the edge, then
  // advances the model using the model's own idea of readiness.
  task automatic step(input bit b, input bit v, input bit s, input bit r, output bit acc);
    bit exp_ready;
    bit consumed;
    in_bit    = b;
    in_valid  = v;
    in_sof    = s;
    out_ready = r;
    @(negedge clock);
    exp_ready = !(frame.size() == FrameLen - 1 && pend && !r);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("lane", 32'(lane), 32'(frame.size()));
    chk("out_valid", {31'd0, out_valid}, {31'd0, pend});
    chk("out_word_hold", {24'd0, out_word}, {24'd0, cur_word});
`ifdef DEMUX_PARITY_EN
    chk("parity_hold", {31'd0, parity_err}, {31'd0, cur_perr});
`endif
    acc      = v && exp_ready;
    consumed = pend && r;
    @(posedge clock);
    #1;
    if (consumed) pend = 1'b0;
    if (acc) begin
      if (s) frame.delete();
      frame.push_back(b);
      if (frame.size() == FrameLen) begin
        logic [7:0] w;
        logic       p;
        for (int k = 0; k < 8; k++) w[k] = frame[k];
        p = 1'b0;
        if (FrameLen == 9) p = (^w) ^ frame[FrameLen-1];
        exp_word_q.push_back(w);
        exp_perr_q.push_back(p);
        cur_word = w;
        cur_perr = p;
        pend     = 1'b1;
        frame.delete();
      end
    end
  endtask

  task automatic idle(input bit r);
    bit acc;
    step(1'b0, 1'b0, 1'b0, r, acc);
  endtask

  // Retry a bit until it is accepted, giving up after a bounded number of cycles.
  task automatic send_bit(input bit b, input bit s, input bit r);
    bit acc;
    for (int t = 0; t < 20; t++) begin
      step(b, 1'b1, s, r, acc);
      if (acc) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got no accept, expected accept within 20 cycles");
  endtask

  // Word in lane order (bit 0 first), followed by a correct even-parity bit if enabled.
  task automatic send_word(input logic [7:0] w, input bit r);
    for (int k = 0; k < 8; k++) send_bit(w[k], 1'b0, r);
    if (FrameLen == 9) send_bit(^w, 1'b0, r);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_bit   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    frame.delete();
    exp_word_q.delete();
    exp_perr_q.delete();
    pend     = 1'b0;
    cur_word = 8'h00;
    cur_perr = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    bit acc;
    out_ready = 1'b1;
    do_reset();
    idle(1'b1);  // reset state

    // Reset and fill: 0,1,0,1,1,0,0,1 -> 8'h9A, valid for exactly one cycle.
    send_word(8'h9A, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: hold 8'hFF, fill all but the completing bit, then release.
    send_word(8'hFF, 1'b0);
    for (int k = 0; k < FrameLen - 1; k++) step(1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b0, 1'b0, acc);  // must stall
    step(1'b0, 1'b1, 1'b0, 1'b1, acc);  // drain and complete on the same edge
    idle(1'b1);
    idle(1'b1);

    // Resync: partial frame dropped, sof restarts at lane 0 -> 8'h01.
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) send_bit(1'b0, 1'b0, 1'b1);
    if (FrameLen == 9) send_bit(1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Gaps: in_valid toggles every cycle for 8'hC3.
    for (int k = 0; k < FrameLen; k++) begin
      logic [8:0] fw;
      fw = {^8'hC3, 8'hC3};
      step(fw[k], 1'b1, 1'b0, 1'b1, acc);
      if (k != FrameLen - 1) step(1'b1, 1'b0, 1'b1, 1'b1, acc);
    end
    idle(1'b1);

    // Mid-frame reset, then 8'h5A.
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0, 1'b1);
    do_reset();
    idle(1'b1);
    send_word(8'h5A, 1'b1);
    idle(1'b1);

`ifdef DEMUX_PARITY_EN
    // 8'h07 with parity 1 is clean; with parity 0 it is an error.
    for (int k = 0; k < 8; k++) send_bit(k < 3, 1'b0, 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);
    idle(1'b1);
    for (int k = 0; k < 8; k++) send_bit(k < 3, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b1);
    idle(1'b1);
`endif

    // Randomized traffic: gaps, stray sof, and downstream backpressure.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
           acc);
    end
    repeat (3) idle(1'b1);
    chk("words_left", 32'(exp_word_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
